// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants: block widths, sync header codes and
// 66b->64b gearbox sequencing.
package eth_pcs_params;

    localparam int unsigned W_DATA = 64;
    localparam int unsigned W_SYNC = 2;

    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b10;

    localparam int unsigned GBX_SEQ_LEN = 33;
    localparam int unsigned W_GBX_SEQ = 6;
    localparam logic [W_GBX_SEQ-1:0] GBX_PAUSE_SEQ = 6'd32;

endpackage

// File: rtl/eth_pcs_tx_gearbox.sv
// TX 66b->64b gearbox: packs sync header + payload into a gapless 64-bit word
// stream, pausing upstream once every 33 output words.
module eth_pcs_tx_gearbox
    import eth_pcs_params::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [W_SYNC-1:0] i_sync_hdr,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [W_DATA-1:0] o_data
);

    logic [W_GBX_SEQ-1:0] q_seq;
    logic [W_DATA-1:0]    q_buf;

    logic [W_GBX_SEQ-1:0] seq_nxt;
    logic [W_DATA-1:0]    buf_nxt;
    logic                 valid_nxt;
    logic [W_DATA-1:0]    data_nxt;

    logic [6:0]           shamt;
    logic [W_DATA-1:0]    buf_mask;
    logic [127:0]         cat;

    always_comb begin
        seq_nxt   = q_seq;
        buf_nxt   = q_buf;
        valid_nxt = 1'b0;
        data_nxt  = o_data;

        o_ready = !i_reset && (q_seq != GBX_PAUSE_SEQ);

        // New block lands directly above the 2*q_seq residual bits
        shamt    = {q_seq, 1'b0};
        buf_mask = (64'd1 << shamt) - 64'd1;
        cat      = ({62'd0, i_data, i_sync_hdr} << shamt) | {64'd0, q_buf & buf_mask};

        if (q_seq == GBX_PAUSE_SEQ) begin
            data_nxt  = q_buf;
            valid_nxt = 1'b1;
            buf_nxt   = '0;
            seq_nxt   = '0;
        end else if (i_valid) begin
            data_nxt  = cat[63:0];
            valid_nxt = 1'b1;
            buf_nxt   = cat[127:64];
            seq_nxt   = q_seq + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_seq   <= '0;
            q_buf   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            q_seq   <= seq_nxt;
            q_buf   <= buf_nxt;
            o_valid <= valid_nxt;
            o_data  <= data_nxt;
        end
    end

endmodule
